// File: rtl/view_param_regs_pkg.sv
// Shared definitions for the view parameter register slice.
//   - ctrl command codes driven on the asynchronous ctrl pins
//   - reset view (the default Mandelbrot framing) in 16-bit fixed point
//   - auto-pan direction encoding carried on value[2:1] of the pan command
package view_param_regs_pkg;

  localparam int unsigned VALUE_W = 13;
  localparam int unsigned CTRL_W  = 3;

  localparam logic [CTRL_W-1:0] CMD_NOP     = 3'b000;
  localparam logic [CTRL_W-1:0] CMD_X_START = 3'b001;
  localparam logic [CTRL_W-1:0] CMD_Y_START = 3'b010;
  localparam logic [CTRL_W-1:0] CMD_X_INC   = 3'b011;
  localparam logic [CTRL_W-1:0] CMD_Y_INC   = 3'b100;
  localparam logic [CTRL_W-1:0] CMD_COMMIT  = 3'b101;
  localparam logic [CTRL_W-1:0] CMD_PAN     = 3'b110;
  localparam logic [CTRL_W-1:0] CMD_ABORT   = 3'b111;

  localparam logic [15:0] X_START_RST = 16'hB000;  // -2.5
  localparam logic [14:0] Y_START_RST = 15'h6000;  // -1.0
  localparam logic [15:0] X_INC_RST   = 16'h002D;
  localparam logic [15:0] Y_INC_RST   = 16'h0026;

  typedef enum logic [1:0] {
    PAN_POS_X = 2'b00,
    PAN_NEG_X = 2'b01,
    PAN_POS_Y = 2'b10,
    PAN_NEG_Y = 2'b11
  } pan_dir_e;

endpackage

// File: rtl/view_param_regs_cmd_sync.sv
// Command front end for view_param_regs.
// Synchronises the slow ctrl/value pins, waits for ctrl to hold the same code
// on two consecutive synchronised cycles, and issues each command once per
// assertion.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   value_i      asynchronous data pins
//   ctrl_i       asynchronous command pins
//   cmd_valid_o  one-cycle strobe: cmd_o/data_o are to be executed
//   cmd_o        command code
//   data_o       synchronised value at execution
module view_param_regs_cmd_sync
  import view_param_regs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value_i,
  input  logic [CTRL_W-1:0]  ctrl_i,
  output logic               cmd_valid_o,
  output logic [CTRL_W-1:0]  cmd_o,
  output logic [VALUE_W-1:0] data_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  state_e             state_q;
  logic [CTRL_W-1:0]  ctrl_s1_q, ctrl_s2_q, ctrl_cmp_q;
  logic [VALUE_W-1:0] value_s1_q, value_s2_q;
  logic               stable;
  logic               fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_s1_q  <= '0;
      ctrl_s2_q  <= '0;
      ctrl_cmp_q <= '0;
      value_s1_q <= '0;
      value_s2_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_s1_q  <= ctrl_i;
      ctrl_s2_q  <= ctrl_s1_q;
      ctrl_cmp_q <= ctrl_s2_q;
      value_s1_q <= value_i;
      value_s2_q <= value_s1_q;
      unique case (state_q)
        ST_IDLE:  if (fire) state_q <= ST_EXEC;
        ST_EXEC:  state_q <= ST_ARMED;
        ST_ARMED: if (stable && (ctrl_cmp_q == CMD_NOP)) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // The action is issued on the edge that enters EXEC rather than one cycle
  // later, keeping pin-to-shadow latency at four clocks.
  always_comb begin
    stable      = (ctrl_s2_q == ctrl_cmp_q);
    fire        = (state_q == ST_IDLE) && stable && (ctrl_cmp_q != CMD_NOP);
    cmd_valid_o = fire;
    cmd_o       = ctrl_cmp_q;
    data_o      = value_s2_q;
  end

endmodule

// File: rtl/view_param_regs.sv
// View parameter registers feeding the coordinate stepper.
// Commands write a shadow view; a commit request copies shadow to active on
// the next frame boundary so a frame never mixes views. Optional auto-pan
// moves the active start point every ANIM_DIV frames.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   value, ctrl  asynchronous data / command pins
//   next_frame   one-cycle frame-boundary pulse
//   x_start      active left-edge X (signed Q3.(BITS-3))
//   y_start      active top-edge Y (signed Q2.(BITS-3))
//   x_inc/y_inc  active per-pixel / per-row steps (unsigned)
//   pending      commit requested, not yet applied
//   pan_on       auto-pan enabled
// BITS must exceed 13 so the value pins fit the fixed-point words.
module view_param_regs
  import view_param_regs_pkg::*;
#(
  parameter int unsigned BITS     = 16,
  parameter int unsigned ANIM_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic               next_frame,
  output logic [BITS-1:0]    x_start,
  output logic [BITS-2:0]    y_start,
  output logic [BITS-1:0]    x_inc,
  output logic [BITS-1:0]    y_inc,
  output logic               pending,
  output logic               pan_on
);

  localparam int unsigned PAD   = BITS - VALUE_W;
  localparam int unsigned CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  localparam logic [BITS-1:0] XS_RST = BITS'(X_START_RST);
  localparam logic [BITS-2:0] YS_RST = (BITS-1)'(Y_START_RST);
  localparam logic [BITS-1:0] XI_RST = BITS'(X_INC_RST);
  localparam logic [BITS-1:0] YI_RST = BITS'(Y_INC_RST);

  logic               cmd_valid;
  logic [CTRL_W-1:0]  cmd;
  logic [VALUE_W-1:0] cmd_data;

  logic [BITS-1:0]  act_xs_q, act_xs_d, sh_xs_q, sh_xs_d;
  logic [BITS-2:0]  act_ys_q, act_ys_d, sh_ys_q, sh_ys_d;
  logic [BITS-1:0]  act_xi_q, act_xi_d, sh_xi_q, sh_xi_d;
  logic [BITS-1:0]  act_yi_q, act_yi_d, sh_yi_q, sh_yi_d;
  logic             pending_q, pending_d;
  logic             pan_on_q, pan_on_d;
  pan_dir_e         pan_dir_q, pan_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  view_param_regs_cmd_sync u_cmd_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_i     (value),
    .ctrl_i      (ctrl),
    .cmd_valid_o (cmd_valid),
    .cmd_o       (cmd),
    .data_o      (cmd_data)
  );

  // Frame-boundary update is resolved first; a command executing on the
  // same edge then acts on the shadow, so a commit always takes the
  // pre-write shadow and abort reloads from the post-boundary active set.
  always_comb begin
    act_xs_d  = act_xs_q;
    act_ys_d  = act_ys_q;
    act_xi_d  = act_xi_q;
    act_yi_d  = act_yi_q;
    sh_xs_d   = sh_xs_q;
    sh_ys_d   = sh_ys_q;
    sh_xi_d   = sh_xi_q;
    sh_yi_d   = sh_yi_q;
    pending_d = pending_q;
    pan_on_d  = pan_on_q;
    pan_dir_d = pan_dir_q;
    cnt_d     = cnt_q;

    if (next_frame && pending_q) begin
      act_xs_d  = sh_xs_q;
      act_ys_d  = sh_ys_q;
      act_xi_d  = sh_xi_q;
      act_yi_d  = sh_yi_q;
      pending_d = 1'b0;
      cnt_d     = '0;
    end else if (next_frame && pan_on_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        // Shadow start tracks the moved start so an edit-free commit is a no-op.
        case (pan_dir_q)
          PAN_POS_X: begin act_xs_d = act_xs_q + act_xi_q; sh_xs_d = act_xs_d; end
          PAN_NEG_X: begin act_xs_d = act_xs_q - act_xi_q; sh_xs_d = act_xs_d; end
          PAN_POS_Y: begin act_ys_d = act_ys_q + act_yi_q[BITS-2:0]; sh_ys_d = act_ys_d; end
          PAN_NEG_Y: begin act_ys_d = act_ys_q - act_yi_q[BITS-2:0]; sh_ys_d = act_ys_d; end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (cmd_valid) begin
      case (cmd)
        CMD_X_START: sh_xs_d = {cmd_data, {PAD{1'b0}}};
        CMD_Y_START: sh_ys_d = {cmd_data[VALUE_W-2:0], {PAD{1'b0}}};
        CMD_X_INC:   sh_xi_d = {{PAD{1'b0}}, cmd_data};
        CMD_Y_INC:   sh_yi_d = {{PAD{1'b0}}, cmd_data};
        CMD_COMMIT:  pending_d = 1'b1;
        CMD_PAN: begin
          pan_on_d  = cmd_data[0];
          pan_dir_d = pan_dir_e'(cmd_data[2:1]);
        end
        CMD_ABORT: begin
          sh_xs_d   = act_xs_d;
          sh_ys_d   = act_ys_d;
          sh_xi_d   = act_xi_d;
          sh_yi_d   = act_yi_d;
          pending_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_xs_q  <= XS_RST;
      act_ys_q  <= YS_RST;
      act_xi_q  <= XI_RST;
      act_yi_q  <= YI_RST;
      sh_xs_q   <= XS_RST;
      sh_ys_q   <= YS_RST;
      sh_xi_q   <= XI_RST;
      sh_yi_q   <= YI_RST;
      pending_q <= 1'b0;
      pan_on_q  <= 1'b0;
      pan_dir_q <= PAN_POS_X;
      cnt_q     <= '0;
    end else begin
      act_xs_q  <= act_xs_d;
      act_ys_q  <= act_ys_d;
      act_xi_q  <= act_xi_d;
      act_yi_q  <= act_yi_d;
      sh_xs_q   <= sh_xs_d;
      sh_ys_q   <= sh_ys_d;
      sh_xi_q   <= sh_xi_d;
      sh_yi_q   <= sh_yi_d;
      pending_q <= pending_d;
      pan_on_q  <= pan_on_d;
      pan_dir_q <= pan_dir_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x_start = act_xs_q;
  assign y_start = act_ys_q;
  assign x_inc   = act_xi_q;
  assign y_inc   = act_yi_q;
  assign pending = pending_q;
  assign pan_on  = pan_on_q;

endmodule

// File: tb/tb_view_param_regs.sv
// Scoreboard bench for view_param_regs: the driver steps a reference model
// each cycle and queues the expected outputs; a monitor compares after every
// clock edge. Directed scenarios add constant checks of documented values.
module tb_view_param_regs;

  localparam int unsigned ANIM_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] value = '0;
  logic [2:0]  ctrl = '0;
  logic        next_frame = 1'b0;
  logic [15:0] x_start, x_inc, y_inc;
  logic [14:0] y_start;
  logic        pending, pan_on;

  always #5 clk = ~clk;

  view_param_regs #(.BITS(16), .ANIM_DIV(ANIM_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .ctrl(ctrl), .next_frame(next_frame),
    .x_start(x_start), .y_start(y_start), .x_inc(x_inc), .y_inc(y_inc),
    .pending(pending), .pan_on(pan_on)
  );

  typedef struct packed {
    logic [15:0] xs;
    logic [14:0] ys;
    logic [15:0] xi;
    logic [15:0] yi;
  } view_t;

  typedef struct packed {
    view_t v;
    logic  pend;
    logic  pan;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- reference model ----------------
  view_t       m_act, m_sh;
  bit          m_pend, m_pan, m_armed;
  bit [1:0]    m_dir;
  int unsigned m_frames;
  logic [15:0] m_pins[$];   // {ctrl, value} as presented at each edge

  function automatic void model_reset();
    m_act    = '{xs: 16'hB000, ys: 15'h6000, xi: 16'h002D, yi: 16'h0026};
    m_sh     = m_act;
    m_pend   = 0;
    m_pan    = 0;
    m_dir    = 2'b00;
    m_frames = 0;
    m_armed  = 0;
    m_pins   = {};
    repeat (3) m_pins.push_back(16'h0000);
  endfunction

  function automatic void model_step(input logic r, input logic [2:0] c,
                                     input logic [12:0] v, input logic nf);
    logic [15:0] now, prev;
    logic [2:0]  code;
    logic [12:0] data;
    bit          fire;
    int          sz;
    if (!r) begin
      model_reset();
      return;
    end
    m_pins.push_back({c, v});
    if (m_pins.size() > 4) void'(m_pins.pop_front());
    sz   = m_pins.size();
    now  = m_pins[sz-3];     // what the synchroniser shows two edges late
    prev = m_pins[sz-4];
    code = now[15:13];
    data = now[12:0];
    fire = 0;
    if (now[15:13] == prev[15:13]) begin
      if (code == 3'b000) m_armed = 0;
      else if (!m_armed) begin fire = 1; m_armed = 1; end
    end

    if (nf && m_pend) begin
      m_act    = m_sh;
      m_pend   = 0;
      m_frames = 0;
    end else if (nf && m_pan) begin
      m_frames++;
      if (m_frames == ANIM_DIV) begin
        m_frames = 0;
        case (m_dir)
          2'b00: begin m_act.xs = m_act.xs + m_act.xi;        m_sh.xs = m_act.xs; end
          2'b01: begin m_act.xs = m_act.xs - m_act.xi;        m_sh.xs = m_act.xs; end
          2'b10: begin m_act.ys = m_act.ys + m_act.yi[14:0];  m_sh.ys = m_act.ys; end
          default: begin m_act.ys = m_act.ys - m_act.yi[14:0]; m_sh.ys = m_act.ys; end
        endcase
      end
    end

    if (fire) begin
      case (code)
        3'b001: m_sh.xs = {data, 3'b000};
        3'b010: m_sh.ys = {data[11:0], 3'b000};
        3'b011: m_sh.xi = {3'b000, data};
        3'b100: m_sh.yi = {3'b000, data};
        3'b101: m_pend = 1;
        3'b110: begin m_pan = data[0]; m_dir = data[2:1]; end
        default: begin m_sh = m_act; m_pend = 0; end
      endcase
    end
  endfunction

  // ---------------- driver helpers ----------------
  task automatic cyc(input logic r, input logic [2:0] c, input logic [12:0] v, input logic nf);
    @(negedge clk);
    rst_n = r; ctrl = c; value = v; next_frame = nf;
    model_step(r, c, v, nf);
    exp_q.push_back('{v: m_act, pend: m_pend, pan: m_pan});
  endtask

  task automatic hold(input logic [2:0] c, input logic [12:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, c, v, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b1, 3'b000, 13'h0, 1'b1);
    cyc(1'b1, 3'b000, 13'h0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, 13'h0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = '{v: '{xs: x_start, ys: y_start, xi: x_inc, yi: y_inc}, pend: pending, pan: pan_on};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got xs=%h ys=%h xi=%h yi=%h pend=%b pan=%b expected xs=%h ys=%h xi=%h yi=%h pend=%b pan=%b",
                   $time, got.v.xs, got.v.ys, got.v.xi, got.v.yi, got.pend, got.pan,
                   e.v.xs, e.v.ys, e.v.xi, e.v.yi, e.pend, e.pan);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [12:0] vals[20];
    logic [2:0]  c;
    logic [12:0] v;
    int          len;
    model_reset();

    // 1: reset
    do_reset();
    settle();
    chk("reset x_start", x_start, 16'hB000);
    chk("reset y_start", {1'b0, y_start}, 16'h6000);
    chk("reset x_inc", x_inc, 16'h002D);
    chk("reset y_inc", y_inc, 16'h0026);
    chk("reset flags", {14'h0, pending, pan_on}, 16'h0000);

    // 2: write without commit, then commit
    hold(3'b001, 13'h0400, 10);
    hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t2 x_start before commit", x_start, 16'hB000);
    hold(3'b101, 13'h0, 5);
    settle();
    chk("t2 pending set", {15'h0, pending}, 16'h0001);
    hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t2 x_start committed", x_start, 16'h2000);
    chk("t2 pending cleared", {15'h0, pending}, 16'h0000);

    // 3: held code with changing value writes once
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vals[i] = 13'($urandom);
      cyc(1'b1, 3'b011, vals[i], 1'b0);
    end
    hold(3'b000, 13'h0, 4);
    hold(3'b101, 13'h0, 5);
    hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t3 x_inc single write", x_inc, {3'b000, vals[1]});

    // 4: auto-pan -X
    do_reset();
    hold(3'b110, 13'h0003, 6);
    hold(3'b000, 13'h0003, 4);
    for (int i = 0; i < 8; i++) frame();
    settle();
    chk("t4 pan x_start", x_start, 16'hAFA6);
    chk("t4 pan_on", {15'h0, pan_on}, 16'h0001);

    // 5a: commit request executing on a frame edge is not lost
    do_reset();
    hold(3'b001, 13'h0123, 6);
    hold(3'b000, 13'h0, 4);
    for (int i = 1; i <= 6; i++) cyc(1'b1, 3'b101, 13'h0, (i == 4));
    hold(3'b000, 13'h0, 4);
    settle();
    chk("t5 no commit same frame", x_start, 16'hB000);
    chk("t5 pending survives", {15'h0, pending}, 16'h0001);
    frame();
    settle();
    chk("t5 commit next frame", x_start, 16'h0918);
    // 5b: write coincident with commit frame
    hold(3'b101, 13'h0, 6);
    hold(3'b000, 13'h0, 4);
    for (int i = 1; i <= 6; i++) cyc(1'b1, 3'b001, 13'h0456, (i == 4));
    hold(3'b000, 13'h0, 4);
    settle();
    chk("t5 old shadow committed", x_start, 16'h0918);
    chk("t5 pending after commit", {15'h0, pending}, 16'h0000);
    hold(3'b101, 13'h0, 6);
    hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t5 new value kept in shadow", x_start, 16'h22B0);

    // 6: abort, then reset during EXEC
    do_reset();
    hold(3'b001, 13'h0200, 6);  hold(3'b000, 13'h0, 4);
    hold(3'b100, 13'h0100, 6);  hold(3'b000, 13'h0, 4);
    hold(3'b101, 13'h0, 6);     hold(3'b000, 13'h0, 4);
    hold(3'b111, 13'h0, 6);     hold(3'b000, 13'h0, 4);
    settle();
    chk("t6 abort clears pending", {15'h0, pending}, 16'h0000);
    hold(3'b101, 13'h0, 6);     hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t6 commit after abort x_start", x_start, 16'hB000);
    chk("t6 commit after abort y_inc", y_inc, 16'h0026);
    hold(3'b011, 13'h0055, 4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'b011, 13'h0055, 1'b0);
    settle();
    chk("t6 reset mid-exec x_inc", x_inc, 16'h002D);
    hold(3'b011, 13'h0055, 6);
    hold(3'b000, 13'h0, 4);
    hold(3'b101, 13'h0, 6);
    hold(3'b000, 13'h0, 4);
    frame();
    settle();
    chk("t6 command after reset", x_inc, 16'h0055);

    // randomized traffic
    do_reset();
    for (int it = 0; it < 300; it++) begin
      c   = 3'($urandom_range(7, 1));
      v   = 13'($urandom);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3, 0) == 0) v = 13'($urandom);
        cyc(($urandom_range(199, 0) != 0), c, v, ($urandom_range(4, 0) == 0));
      end
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        cyc(($urandom_range(199, 0) != 0), 3'b000, v, ($urandom_range(4, 0) == 0));
    end

    cyc(1'b1, 3'b000, 13'h0, 1'b0);
    settle();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
